mc14500_control: RTL

MC14500_CONTROL -- requirements
Module: mc14500_control

---
 rtl/mc14500_control_if.sv | 24 ++
 rtl/mc14500_control.sv | 66 ++++++
 2 files changed

// File: rtl/mc14500_control_if.sv
// mc14500_control_if: instruction/PC/data signals between the MC14500 control block and its environment
interface mc14500_control_if #(parameter int ADDR_W = 8);
  logic [3:0] opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_in;
  logic data_in;
  logic pc_write;
  logic [ADDR_W-1:0] pc_target;
  logic rr;
  logic data_out;
  logic write_en;
  logic flag_0;
  logic flag_f;
  logic jmp;
  logic rtn;
  modport master (
    output opcode, operand, pc_in, data_in,
    input pc_write, pc_target, rr, data_out, write_en, flag_0, flag_f, jmp, rtn
  );
  modport slave (
    input opcode, operand, pc_in, data_in,
    output pc_write, pc_target, rr, data_out, write_en, flag_0, flag_f, jmp, rtn
  );
endinterface

// File: rtl/mc14500_control.sv
// mc14500_control: one-instruction-per-cycle MC14500 control unit with skip and single-entry return
module mc14500_control #(parameter int ADDR_W = 8) (
  input logic clk,
  input logic reset_n,
  mc14500_control_if.slave b
);
  logic rr, ien, oen, skip, ret_valid, data_out, write_en, flag_0, flag_f, jmp, rtn;
  logic [ADDR_W-1:0] ret_addr;
  logic [15:0] hit;
  logic d, rr_n;
  assign hit = skip ? 16'd0 : 16'd1 << b.opcode;
  assign d = b.data_in & ien;
  always_comb begin
    rr_n = rr;
    case (b.opcode)
      4'h1: rr_n = d;
      4'h2: rr_n = ~d;
      4'h3: rr_n = rr & d;
      4'h4: rr_n = rr & ~d;
      4'h5: rr_n = rr | d;
      4'h6: rr_n = rr | ~d;
      4'h7: rr_n = ~(rr ^ d);
      default: rr_n = rr;
    endcase
  end
  assign b.pc_write = reset_n & (hit[12] | (hit[13] & ret_valid));
  assign b.pc_target = (hit[13] & ret_valid) ? ret_addr : b.operand;
  assign b.rr = rr;
  assign b.data_out = data_out;
  assign b.write_en = write_en;
  assign b.flag_0 = flag_0;
  assign b.flag_f = flag_f;
  assign b.jmp = jmp;
  assign b.rtn = rtn;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr <= 1'b0;
      ien <= 1'b1;
      oen <= 1'b1;
      skip <= 1'b0;
      ret_valid <= 1'b0;
      ret_addr <= '0;
      data_out <= 1'b0;
      write_en <= 1'b0;
      flag_0 <= 1'b0;
      flag_f <= 1'b0;
      jmp <= 1'b0;
      rtn <= 1'b0;
    end else begin
      flag_0 <= hit[0];
      flag_f <= hit[15];
      jmp <= hit[12];
      rtn <= hit[13];
      write_en <= (hit[8] | hit[9]) & oen;
      skip <= (hit[14] & ~rr) | hit[13];
      if (!skip) rr <= rr_n;
      if (hit[8] | hit[9]) data_out <= rr ^ hit[9];
      if (hit[10]) ien <= b.data_in;
      if (hit[11]) oen <= b.data_in;
      if (hit[12]) begin
        ret_addr <= b.pc_in + 1'b1;
        ret_valid <= 1'b1;
      end else if (hit[13]) ret_valid <= 1'b0;
    end
  end
endmodule
